i2c_slave_regfile: RTL and testbench

I2C target (slave) endpoint backed by a 16-byte register file. It is the far end of the bus driven by `i2c_top`, and serves as the on-chip responder and bench model for master write and read transfers. It oversamples SCL/SDA on the I2C core clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and accepts pointer-addressed writes and sequential reads. Open-drain SDA drive only; no clock stretching.

---
 rtl/i2c_slave_regfile.sv | 179 +++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a 16-byte register file, pointer-addressed writes and sequential reads.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a 3-sample agreement filter on SCL/SDA.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h25
) (
  input  logic       i2c_core_clk_i,
  input  logic       i2c_core_rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [3:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_s, sda_s;
  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start, stop;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, byte_in;
  logic [3:0] ptr_q, ptr_d;
  logic rw_q, rw_d, oe_d, commit, busy_d;
  logic [7:0] regs [16];
  always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni)
    if (!i2c_core_rst_ni) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni)
    if (!i2c_core_rst_ni) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s[1]};
      sda_h <= {sda_h[0], sda_s[1]};
      if (scl_h == {2{scl_s[1]}}) scl_f <= scl_s[1];
      if (sda_h == {2{sda_s[1]}}) sda_f <= sda_s[1];
    end
`else
  assign scl_f = scl_s[1];
  assign sda_f = sda_s[1];
`endif
  always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni)
    if (!i2c_core_rst_ni) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start    = scl_f & scl_p & sda_p & ~sda_f;
  assign stop     = scl_f & scl_p & ~sda_p & sda_f;
  assign byte_in  = {sh_q[6:0], sda_f};
  assign busy_d   = (state_d == ADDR_ACK) | (busy_o & (state_d != IDLE));
  // In ACK states sda_oe_o doubles as the phase flag: first fall drives ACK, second fall ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = sda_oe_o;
    commit  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
            rw_d    = byte_in[0];
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_o) oe_d = 1'b1;
          else if (rw_q) begin
            state_d = RD_DATA;
            oe_d    = ~regs[ptr_q][7];
            sh_d    = {regs[ptr_q][6:0], 1'b0};
            cnt_d   = 3'd1;
          end else begin
            state_d = PTR;
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
          end
        end
        PTR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = PTR_ACK;
            ptr_d   = byte_in[3:0];
          end
        end
        PTR_ACK, WR_ACK: if (scl_fall) begin
          oe_d = ~sda_oe_o;
          if (sda_oe_o) begin
            state_d = WR_DATA;
            cnt_d   = 3'd0;
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = WR_ACK;
            commit  = 1'b1;
            ptr_d   = ptr_q + 4'd1;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            state_d = RD_ACK;
            oe_d    = 1'b0;
            ptr_d   = ptr_q + 4'd1;
          end else begin
            oe_d  = ~sh_q[7];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end
        end
        RD_ACK: if (scl_rise && sda_f) state_d = IDLE;
          else if (scl_fall) begin
            state_d = RD_DATA;
            oe_d    = ~regs[ptr_q][7];
            sh_d    = {regs[ptr_q][6:0], 1'b0};
            cnt_d   = 3'd1;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni)
    if (!i2c_core_rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'd0;
      ptr_q      <= 4'd0;
      rw_q       <= 1'b0;
      sda_oe_o   <= 1'b0;
      busy_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= 4'd0;
      wr_data_o  <= 8'd0;
      regs       <= '{default: 8'd0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_o   <= oe_d;
      busy_o     <= busy_d;
      wr_valid_o <= commit;
      if (commit) begin
        regs[ptr_q] <= byte_in;
        wr_addr_o   <= ptr_q;
        wr_data_o   <= byte_in;
      end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: directed bus-level bench for i2c_slave_regfile with a bit-banged master.
module tb_i2c_slave_regfile;
  localparam int H = 16;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam logic [7:0] GL_EXP = 8'h5A;
`else
  localparam logic [7:0] GL_EXP = 8'h2D;
`endif
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, wr_valid, busy, sda_bus;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [11:0] cq [$];
  int oe_hits = 0, busy_hits = 0, n_checks = 0, n_fail = 0;
  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_slave_regfile dut (
    .i2c_core_clk_i(clk), .i2c_core_rst_ni(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe_o(sda_oe), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );
  always @(negedge clk) begin
    if (wr_valid) cq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_hits++;
    if (busy) busy_hits++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; wt(H); scl_m = 1'b1; wt(H); sda_m = 1'b0; wt(H); scl_m = 1'b0; wt(H);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; wt(H); scl_m = 1'b1; wt(H); sda_m = 1'b1; wt(H);
  endtask
  task automatic send_bit(input logic b);
    sda_m = b; wt(H); scl_m = 1'b1; wt(H); scl_m = 1'b0; wt(H);
  endtask
  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wt(H); scl_m = 1'b1; wt(H / 2); b = sda_bus; wt(H / 2); scl_m = 1'b0; wt(H);
  endtask
  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    ack = ~a;
  endtask
  task automatic read_byte(output logic [7:0] v, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(v[i]);
    send_bit(nack);
  endtask
  initial begin
    logic ack, a;
    logic [7:0] d;
    logic [7:0] wd [3] = '{8'h8A, 8'h2B, 8'hC3};
    logic [7:0] gd = 8'h5A;
    int base, oe0, busy0;
    wt(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    wt(4);
    base = cq.size();
    i2c_start();
    write_byte(8'h4A, ack); check("wb_ack_addr", ack, 1);
    check("wb_busy", busy, 1);
    write_byte(8'h02, ack); check("wb_ack_ptr", ack, 1);
    for (int i = 0; i < 3; i++) begin
      write_byte(wd[i], ack);
      check($sformatf("wb_ack_d%0d", i), ack, 1);
    end
    i2c_stop(); wt(8);
    check("wb_count", cq.size() - base, 3);
    for (int i = 0; i < 3; i++) check($sformatf("wb_commit%0d", i), cq[base + i], {4'(2 + i), wd[i]});
    check("wb_busy_after", busy, 0);
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h0F, ack); write_byte(8'h94, ack); write_byte(8'h21, ack);
    i2c_stop();
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h0F, ack);
    i2c_start();
    write_byte(8'h4B, ack); check("rd_ack_addr", ack, 1);
    read_byte(d, 1'b0); check("rd_byte15", d, 8'h94);
    read_byte(d, 1'b1); check("rd_byte0_wrap", d, 8'h21);
    i2c_stop();
    i2c_start();
    write_byte(8'h4B, ack);
    read_byte(d, 1'b1); check("rd_ptr_is_1", d, 8'h00);
    i2c_stop(); wt(8);
    base = cq.size(); oe0 = oe_hits; busy0 = busy_hits;
    i2c_start();
    write_byte(8'h68, ack); check("mm_no_ack_addr", ack, 0);
    write_byte(8'h11, ack); check("mm_no_ack_data", ack, 0);
    i2c_stop(); wt(8);
    check("mm_oe_never", oe_hits - oe0, 0);
    check("mm_busy_never", busy_hits - busy0, 0);
    check("mm_no_commit", cq.size() - base, 0);
    base = cq.size();
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h05, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop(); wt(8);
    check("sm_no_commit", cq.size() - base, 0);
    check("sm_oe", sda_oe, 0);
    check("sm_busy", busy, 0);
    i2c_start();
    write_byte(8'h4A, ack); check("sm_next_ack", ack, 1);
    write_byte(8'h06, ack); write_byte(8'h77, ack); check("sm_next_data_ack", ack, 1);
    i2c_stop(); wt(8);
    check("sm_next_count", cq.size() - base, 1);
    check("sm_next_commit", cq[base], 12'h677);
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h06, ack);
    i2c_start();
    write_byte(8'h4B, ack);
    check("rr_driving_zero", sda_oe, 1);
    rst_n = 1'b0;
    #1 check("rr_oe_async", sda_oe, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wt(4);
    check("rr_busy_rst", busy, 0);
    rst_n = 1'b1;
    wt(4);
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h06, ack);
    i2c_start();
    write_byte(8'h4B, ack);
    read_byte(d, 1'b1); check("rr_reg6_cleared", d, 8'h00);
    i2c_stop(); wt(8);
    base = cq.size();
    i2c_start();
    write_byte(8'h4A, ack); write_byte(8'h08, ack);
    sda_m = gd[7]; wt(H); scl_m = 1'b1; wt(5); scl_m = 1'b0; wt(2); scl_m = 1'b1; wt(H - 7); scl_m = 1'b0; wt(H);
    for (int i = 6; i >= 0; i--) send_bit(gd[i]);
    recv_bit(a);
    i2c_stop(); wt(8);
    check("gl_count", cq.size() - base, 1);
    check("gl_commit", cq[base], {4'h8, GL_EXP});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
